regfile_mp_scoreboard: RTL and testbench

Parametrised multi-port integer register file for the MinCPU pipeline. It has NUM_RD read ports and NUM_WR write ports, with same-cycle write-to-read bypass. A per-register busy scoreboard is set at issue and cleared at writeback, so decode can detect RAW hazards without external tracking. It replaces the fixed 2R/1W file and sits between decode (reads, issue) and writeback (writes).

---
 rtl/regfile_pkg.sv | 50 +++++
 rtl/regfile_mp_scoreboard_scoreboard.sv | 70 +++++++
 rtl/regfile_mp_scoreboard.sv | 105 ++++++++++
 tb/tb_regfile_mp_scoreboard.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file and its scoreboard.
// Holds default geometry, the hardwired-zero address and the write-port
// winner resolution used by both the read bypass and the busy clear logic.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    localparam int ZERO_ADDR = 0;

    // Write-port resolution works on fixed maximal widths so a single
    // function serves every parameterisation; callers zero-extend into these.
    localparam int MAX_WR = 2;
    localparam int MAX_AW = 8;
    localparam int WP_W   = 1;   // clog2(MAX_WR)

    typedef logic [MAX_WR-1:0]             wr_en_t;
    typedef logic [MAX_WR-1:0][MAX_AW-1:0] wr_addr_t;

    typedef struct packed {
        logic            hit;
        logic [WP_W-1:0] port;
    } wr_hit_t;

    // Ascending scan: a later (higher-index) port that also matches overrides
    // the earlier one, so the highest-index enabled writer wins.
    function automatic wr_hit_t wr_winner(input wr_en_t            en,
                                          input wr_addr_t          addr,
                                          input logic [MAX_AW-1:0] a);
        wr_hit_t res;
        res = '0;
        for (int p = 0; p < MAX_WR; p++) begin
            if (en[p] && (addr[p] == a)) begin
                res.hit  = 1'b1;
                res.port = WP_W'(p);
            end
        end
        return res;
    endfunction

    function automatic logic wr_hit(input wr_en_t            en,
                                    input wr_addr_t          addr,
                                    input logic [MAX_AW-1:0] a);
        wr_hit_t res;
        res = wr_winner(en, addr, a);
        return res.hit;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback or flush.
// Ports: clk/rst_n; extended write enables/addresses; issue and flush controls;
// packed read addresses in, per-read-port busy (combinational) and raw busy vector out.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  wr_en_t                       i_wr_en,
    input  wr_addr_t                     i_wr_addr,
    input  logic                         i_iss_en,
    input  logic [ADDR_WIDTH-1:0]        i_iss_addr,
    input  logic                         i_flush,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_RD-1:0]            o_rd_busy,
    output logic [NUM_REGS-1:0]          o_busy_vec
);

    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_busy_nxt;
    logic [NUM_REGS-1:0]   w_wb_clr;
    logic [ADDR_WIDTH-1:0] w_rd_a [NUM_RD];

    // Priority: flush, then writeback clear, then issue set. Issue therefore
    // wins over both, since the freshly issued writer is still outstanding.
    always_comb begin
        w_wb_clr   = '0;
        w_busy_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_wb_clr[r]   = wr_hit(i_wr_en, i_wr_addr, MAX_AW'(r));
            w_busy_nxt[r] = i_flush ? 1'b0 : r_busy[r];
            if (w_wb_clr[r]) begin
                w_busy_nxt[r] = 1'b0;
            end
            if (i_iss_en && (i_iss_addr == ADDR_WIDTH'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end
            if ((ZERO_REG != 0) && (r == ZERO_ADDR)) begin
                w_busy_nxt[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // A same-cycle writeback bypasses the data, so the operand is ready now.
    always_comb begin
        o_rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_rd_a[k]    = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            o_rd_busy[k] = rst_n && r_busy[w_rd_a[k]]
                         && !wr_hit(i_wr_en, i_wr_addr, MAX_AW'(w_rd_a[k]))
                         && !((ZERO_REG != 0) && (w_rd_a[k] == ADDR_WIDTH'(ZERO_ADDR)));
        end
    end

    assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with same-cycle write-to-read bypass and busy scoreboard.
// Ports: clk/rst_n; NUM_RD packed read addr/data/busy; NUM_WR packed write en/addr/data;
// issue (i_iss_en/i_iss_addr), i_flush, and o_busy_vec raw scoreboard state.
module regfile_mp_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data,
    output logic [NUM_RD-1:0]            o_rd_busy,
    input  logic [NUM_WR-1:0]            i_wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] i_wr_data,
    input  logic                         i_iss_en,
    input  logic [ADDR_WIDTH-1:0]        i_iss_addr,
    input  logic                         i_flush,
    output logic [NUM_REGS-1:0]          o_busy_vec
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    wr_en_t                w_wr_en_ext;
    wr_addr_t              w_wr_addr_ext;
    logic [DATA_WIDTH-1:0] w_wr_dat [MAX_WR];
    logic [ADDR_WIDTH-1:0] w_rd_a   [NUM_RD];
    wr_hit_t               w_rd_hit [NUM_RD];

    // Unused write-port slots stay disabled so the shared resolver ignores them.
    always_comb begin
        w_wr_en_ext   = '0;
        w_wr_addr_ext = '0;
        for (int p = 0; p < MAX_WR; p++) begin
            w_wr_dat[p] = '0;
        end
        for (int p = 0; p < NUM_WR; p++) begin
            w_wr_en_ext[p]   = i_wr_en[p];
            w_wr_addr_ext[p] = MAX_AW'(i_wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]);
            w_wr_dat[p]      = i_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Ports are applied in ascending order; the last non-blocking assignment
    // to a shared address lands, so the higher-index port wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (i_wr_en[p] &&
                    !((ZERO_REG != 0) &&
                      (i_wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(ZERO_ADDR)))) begin
                    r_regs[i_wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= i_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Read mux: hardwired zero, then bypass from the winning writer, then storage.
    // Outputs are held at zero while reset is asserted, even if writes are driven.
    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_rd_a[k]   = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            w_rd_hit[k] = wr_winner(w_wr_en_ext, w_wr_addr_ext, MAX_AW'(w_rd_a[k]));
            if (!rst_n) begin
                o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ((ZERO_REG != 0) && (w_rd_a[k] == ADDR_WIDTH'(ZERO_ADDR))) begin
                o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if (w_rd_hit[k].hit) begin
                o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_wr_dat[w_rd_hit[k].port];
            end else begin
                o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_rd_a[k]];
            end
        end
    end

    rf_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_wr_en_ext),
        .i_wr_addr  (w_wr_addr_ext),
        .i_iss_en   (i_iss_en),
        .i_iss_addr (i_iss_addr),
        .i_flush    (i_flush),
        .i_rd_addr  (i_rd_addr),
        .o_rd_busy  (o_rd_busy),
        .o_busy_vec (o_busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Self-checking bench for regfile_mp_scoreboard (2 read, 2 write ports, zero register).
// Directed steps followed by randomized traffic against an array-based model.
// Inputs change 1 ns after the rising edge; outputs are sampled before the next edge.
module tb_regfile_mp_scoreboard;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic clk = 1'b0;
    logic rst_n;

    logic [AW-1:0]  ra [NRD];
    logic [NWR-1:0] we;
    logic [AW-1:0]  wa [NWR];
    logic [DW-1:0]  wd [NWR];
    logic           iss_en;
    logic [AW-1:0]  iss_addr;
    logic           flush;

    logic [NRD*AW-1:0] rd_addr_bus;
    logic [NWR*AW-1:0] wr_addr_bus;
    logic [NWR*DW-1:0] wr_data_bus;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic [NR-1:0]     busy_vec;

    assign rd_addr_bus = {ra[1], ra[0]};
    assign wr_addr_bus = {wa[1], wa[0]};
    assign wr_data_bus = {wd[1], wd[0]};

    regfile_mp_scoreboard #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .ADDR_WIDTH (AW),
        .NUM_RD     (NRD),
        .NUM_WR     (NWR),
        .ZERO_REG   (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_addr  (rd_addr_bus),
        .o_rd_data  (rd_data),
        .o_rd_busy  (rd_busy),
        .i_wr_en    (we),
        .i_wr_addr  (wr_addr_bus),
        .i_wr_data  (wr_data_bus),
        .i_iss_en   (iss_en),
        .i_iss_addr (iss_addr),
        .i_flush    (flush),
        .o_busy_vec (busy_vec)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural values and pending-writer flags.
    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_busy;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value a reader should see this cycle: zero register, newest same-cycle write, or stored value.
    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
        for (int p = NWR-1; p >= 0; p--) begin
            if (we[p] && wa[p] == a) return wd[p];
        end
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        for (int p = 0; p < NWR; p++) begin
            if (we[p] && wa[p] == a) return 1'b0;
        end
        return m_busy[a];
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("%s_rd_data%0d", tag, k), rd_data[k*DW +: DW], exp_data(ra[k]));
            chk($sformatf("%s_rd_busy%0d", tag, k), {31'b0, rd_busy[k]}, {31'b0, exp_busy(ra[k])});
        end
        chk($sformatf("%s_busy_vec", tag), busy_vec, m_busy);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    // Apply this cycle's inputs to the model, then advance past the rising edge.
    task automatic tick();
        logic [NR-1:0] nb;
        nb = m_busy;
        if (flush) nb = '0;
        for (int p = 0; p < NWR; p++) begin
            if (we[p]) begin
                if (wa[p] != 0) m_regs[wa[p]] = wd[p];
                nb[wa[p]] = 1'b0;
            end
        end
        if (iss_en && iss_addr != 0) nb[iss_addr] = 1'b1;
        nb[0] = 1'b0;
        m_busy = nb;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0; iss_en = 1'b0; flush = 1'b0; iss_addr = '0;
        wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        ra[0] = '0; ra[1] = '0;
        model_reset();
        #2;

        // Reset state across the whole address range.
        for (int a = 0; a < NR; a++) begin
            ra[0] = AW'(a); ra[1] = AW'(NR-1-a);
            #1;
            chk("reset_rd_data0", rd_data[DW-1:0], '0);
            chk("reset_rd_busy",  {30'b0, rd_busy}, '0);
            chk("reset_busy_vec", busy_vec, '0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("post_reset");

        // Bypass then stored read of x5; x0 writes are dropped.
        we[0] = 1'b1; wa[0] = 5; wd[0] = 32'hDEADBEEF; ra[0] = 5; ra[1] = 5;
        #1;
        chk("bypass_x5", rd_data[DW-1:0], 32'hDEADBEEF);
        check_all("t2_bypass");
        tick(); idle(); #1;
        chk("stored_x5", rd_data[DW+:DW], 32'hDEADBEEF);
        check_all("t2_stored");
        we[0] = 1'b1; wa[0] = 0; wd[0] = 32'h1234; ra[0] = 0;
        #1;
        chk("x0_bypass_zero", rd_data[DW-1:0], '0);
        tick(); idle(); #1;
        chk("x0_stored_zero", rd_data[DW-1:0], '0);

        // Issue x7, observe busy, clear it by writeback three cycles later.
        iss_en = 1'b1; iss_addr = 7; ra[0] = 7;
        tick(); idle(); #1;
        chk("x7_busy_vec_set", {31'b0, busy_vec[7]}, 32'd1);
        chk("x7_rd_busy_set",  {31'b0, rd_busy[0]},  32'd1);
        tick();
        tick();
        we[0] = 1'b1; wa[0] = 7; wd[0] = 32'h55;
        #1;
        chk("x7_rd_busy_wb",  {31'b0, rd_busy[0]}, '0);
        chk("x7_rd_data_wb",  rd_data[DW-1:0], 32'h55);
        check_all("t3_wb");
        tick(); idle(); #1;
        chk("x7_busy_vec_clr", {31'b0, busy_vec[7]}, '0);
        check_all("t3_after");

        // Issue beats writeback; flush plus issue leaves only the new writer.
        iss_en = 1'b1; iss_addr = 9;
        tick();
        iss_en = 1'b1; iss_addr = 9; we[0] = 1'b1; wa[0] = 9; wd[0] = 32'hA; ra[0] = 9;
        #1;
        check_all("t4_iss_wb");
        tick(); idle(); #1;
        chk("x9_busy_kept", {31'b0, busy_vec[9]}, 32'd1);
        chk("x9_data",      rd_data[DW-1:0], 32'hA);
        chk("x9_rd_busy",   {31'b0, rd_busy[0]}, 32'd1);
        iss_en = 1'b1; iss_addr = 3; flush = 1'b1;
        tick(); idle(); #1;
        chk("flush_iss_x3", busy_vec, 32'h0000_0008);

        // Two writers on one address: port 1 wins; distinct addresses both land.
        we = 2'b11; wa[0] = 4; wd[0] = 32'h11; wa[1] = 4; wd[1] = 32'h22; ra[0] = 4;
        #1;
        chk("dual_same_bypass", rd_data[DW-1:0], 32'h22);
        tick(); idle(); #1;
        chk("dual_same_stored", rd_data[DW-1:0], 32'h22);
        we = 2'b11; wa[0] = 4; wd[0] = 32'h44; wa[1] = 6; wd[1] = 32'h66; ra[0] = 4; ra[1] = 6;
        #1;
        check_all("dual_diff_bypass");
        tick(); idle(); #1;
        chk("dual_diff_x4", rd_data[DW-1:0],  32'h44);
        chk("dual_diff_x6", rd_data[DW+:DW],  32'h66);

        // Randomized traffic; narrow address window half the time to force collisions.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NRD; k++) ra[k] = AW'($urandom_range(0, NR-1));
            for (int p = 0; p < NWR; p++) begin
                we[p] = 1'($urandom_range(0, 1));
                wa[p] = AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, NR-1));
                wd[p] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                ra[0] = wa[0];
            end
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, NR-1));
            flush    = ($urandom_range(0, 15) == 0);
            #1;
            check_all("rnd");
            tick();
        end
        idle();

        // Populate data and busy everywhere, then reset between edges.
        we[0] = 1'b1; wa[0] = 2;  wd[0] = 32'hCAFE0002;
        we[1] = 1'b1; wa[1] = 10; wd[1] = 32'hCAFE000A;
        tick(); idle();
        we[0] = 1'b1; wa[0] = 20; wd[0] = 32'hCAFE0014;
        tick(); idle();
        for (int a = 1; a < NR; a++) begin
            iss_en = 1'b1; iss_addr = AW'(a);
            tick();
        end
        idle();
        ra[0] = 2; ra[1] = 10;
        #1;
        chk("pre_rst_busy_vec", busy_vec, 32'hFFFF_FFFE);
        chk("pre_rst_x2",       rd_data[DW-1:0], 32'hCAFE0002);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_busy_vec", busy_vec, '0);
        chk("async_rst_x2",  rd_data[DW-1:0], '0);
        chk("async_rst_x10", rd_data[DW+:DW], '0);
        ra[0] = 20; ra[1] = 7;
        #1;
        check_all("async_rst");
        @(negedge clk); rst_n = 1'b1;
        #1;
        ra[0] = 2; ra[1] = 20;
        #1;
        check_all("post_async_rst");
        chk("post_rst_x20", rd_data[DW+:DW], '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
